lsu_mem_if: RTL

- Load/store unit between the core's data-memory outputs and a handshaked data RAM port.
- Accepts the core's read/write enables, address, store data and funct3.
- Generates byte enables, sequences the request/grant/response handshake and holds the core with a stall while the access is in flight.
- Returns sign/zero-extended load data through the MemtoReg mux as the register-file write value.

---
 rtl/lsu_mem_if.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the core's data-memory outputs and a
// handshaked data RAM port.
//
// Handshake: mem_req is valid-style and all mem_* request outputs stay
// stable while mem_req is high. The request is accepted on a cycle where
// mem_gnt is high. Load data arrives on a later cycle with mem_rvalid.
//
// Ports:
//   CLOCK, RST_n            clock, synchronous active-low reset
//   ena_rd / ena_wr         core load / store request (store wins if both)
//   alu_out                 byte address, also the non-memory writeback value
//   dataram_wr              store data (rs2)
//   funct3                  access size/sign (instr[14:12])
//   MemtoReg                selects load data for writeback
//   datareg_wr              register-file write data
//   stall                   core holds PC and instruction while high
//   mem_err                 one-cycle error pulse (illegal access or timeout)
//   mem_req/we/addr/be/wdata  request side of the RAM port
//   mem_gnt                 request accepted
//   mem_rvalid/mem_rdata    read response
//   dbg_state_o             FSM state: 0 IDLE, 1 REQ, 2 WAIT_R, 3 DONE
//
// Build option: define MEM_TIMEOUT_EN to abort a transaction that waits
// TIMEOUT_CYCLES cycles in REQ or WAIT_R; otherwise the unit waits forever.
module lsu_mem_if #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLOCK,
    input  logic        RST_n,
    input  logic        ena_rd,
    input  logic        ena_wr,
    input  logic [31:0] alu_out,
    input  logic [31:0] dataram_wr,
    input  logic [2:0]  funct3,
    input  logic        MemtoReg,
    output logic [31:0] datareg_wr,
    output logic        stall,
    output logic        mem_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic        mem_err_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] load_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;

    logic        req;
    logic        f3_legal;
    logic        misaligned;
    logic        accept;
    logic        timeout;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane_word;
    logic [31:0] load_d;

    assign req = ena_rd | ena_wr;

    // Unsigned load encodings (1xx) have no store counterpart.
    always_comb begin
        f3_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ~ena_wr;
            default:                f3_legal = 1'b0;
        endcase
    end

    assign misaligned = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
                        ((funct3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));
    assign accept     = req & f3_legal & ~misaligned;

    // Lane enables and replicated write data; the RAM picks the lanes via be.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = dataram_wr;
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << alu_out[1:0];
                wdata_d = {4{dataram_wr[7:0]}};
            end
            2'b01: begin
                be_d    = alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{dataram_wr[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = dataram_wr;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend per funct3.
    assign lane_word = mem_rdata >> {offset_q, 3'b000};

    always_comb begin
        load_d = lane_word;
        case (funct3_q)
            3'b000:  load_d = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_d = {24'h0, lane_word[7:0]};
            3'b001:  load_d = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_d = {16'h0, lane_word[15:0]};
            default: load_d = lane_word;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Counts cycles spent in the current wait state; zero on entry to REQ
    // (coming from IDLE) and on entry to WAIT_R (grant cycle).
    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            cnt_q <= '0;
        end else if ((state_q == S_IDLE) || (state_q == S_DONE) ||
                     ((state_q == S_REQ) && mem_gnt)) begin
            cnt_q <= '0;
        end else if (!timeout) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            load_q      <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
        end else begin
            mem_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_REQ;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= ena_wr;
                        mem_addr_q  <= {alu_out[31:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        funct3_q    <= funct3;
                        offset_q    <= alu_out[1:0];
                    end else if (req) begin
                        mem_err_q <= 1'b1;
                        load_q    <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_we_q ? S_DONE : S_WAIT_R;
                    end else if (timeout) begin
                        mem_req_q <= 1'b0;
                        mem_err_q <= 1'b1;
                        load_q    <= '0;
                        state_q   <= S_DONE;
                    end
                end
                S_WAIT_R: begin
                    if (mem_rvalid) begin
                        load_q  <= load_d;
                        state_q <= S_DONE;
                    end else if (timeout) begin
                        mem_err_q <= 1'b1;
                        load_q    <= '0;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // One released cycle; a request seen here is not launched.
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The launch cycle must already stall, before the FSM leaves IDLE.
    assign stall = ((state_q == S_IDLE) && accept) ||
                   (state_q == S_REQ) || (state_q == S_WAIT_R);

    assign datareg_wr  = MemtoReg ? load_q : alu_out;
    assign mem_err     = mem_err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule
